// File: rtl/seven_seg_mux.sv
// Multiplexed common-anode seven-segment driver with a built-in scan prescaler and PWM brightness.
// Display values are double-buffered and change only on a frame boundary, so a frame never tears.
module seven_seg_mux #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1024,
   parameter int BRIGHT_W = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  load,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PRESCALE - 1);
   localparam logic [DIG_W-1:0]    DIG_LAST   = DIG_W'(DIGITS - 1);
   localparam logic [BRIGHT_W-1:0] PHASE_LAST = '1;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Scan timing state
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [BRIGHT_W-1:0] phase_q, phase_d;
   logic [DIG_W-1:0]    digit_q, digit_d;

   // Pending (written by load) and shadow (displayed) buffers
   logic [4*DIGITS-1:0] pend_value_q, pend_value_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                pend_valid_q, pend_valid_d;
   logic [4*DIGITS-1:0] shd_value_q, shd_value_d;
   logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
   logic [DIGITS-1:0]   shd_blank_q, shd_blank_d;

   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                tick;
   logic                slot_end;
   logic                frame_end;
   logic                lit;
   logic [3:0]          cur_nib;
   logic [3:0]          nib_arr [DIGITS];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_nib
         assign nib_arr[gi] = shd_value_q[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      tick      = (pre_cnt_q == PRE_LAST);
      slot_end  = tick && (phase_q == PHASE_LAST);
      frame_end = slot_end && (digit_q == DIG_LAST);

      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      phase_d   = tick ? phase_q + 1'b1 : phase_q;
      digit_d   = digit_q;
      if (slot_end) begin
         digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
      end
   end

   // A load on the frame-boundary tick is newer than anything pending, so it goes straight to shadow.
   always_comb begin
      pend_value_d = pend_value_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_valid_d = pend_valid_q;
      shd_value_d  = shd_value_q;
      shd_dp_d     = shd_dp_q;
      shd_blank_d  = shd_blank_q;

      if (frame_end) begin
         pend_valid_d = 1'b0;
         if (load) begin
            shd_value_d = value;
            shd_dp_d    = dp;
            shd_blank_d = blank;
         end else if (pend_valid_q) begin
            shd_value_d = pend_value_q;
            shd_dp_d    = pend_dp_q;
            shd_blank_d = pend_blank_q;
         end
      end else if (load) begin
         pend_value_d = value;
         pend_dp_d    = dp;
         pend_blank_d = blank;
         pend_valid_d = 1'b1;
      end
   end

   always_comb begin
      cur_nib = nib_arr[digit_q];
      lit     = (phase_q < brightness) && !shd_blank_q[digit_q];
      seg_d   = 8'hFF;
      an_d    = '1;
      if (lit) begin
         seg_d = {~shd_dp_q[digit_q], hex7(cur_nib)};
         an_d  = ~(DIGITS'(1) << digit_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_q    <= '0;
         phase_q      <= '0;
         digit_q      <= '0;
         pend_value_q <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_valid_q <= 1'b0;
         shd_value_q  <= '0;
         shd_dp_q     <= '0;
         shd_blank_q  <= '1;
         seg_q        <= 8'hFF;
         an_q         <= '1;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         phase_q      <= phase_d;
         digit_q      <= digit_d;
         pend_value_q <= pend_value_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_valid_q <= pend_valid_d;
         shd_value_q  <= shd_value_d;
         shd_dp_q     <= shd_dp_d;
         shd_blank_q  <= shd_blank_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux at DIGITS=4, PRESCALE=4, BRIGHT_W=2 (16-clk slot, 64-clk frame).
// After posedge k (counted from reset release) the outputs reflect scan position k-1.
module tb_seven_seg_mux;

   logic        clk;
   logic        reset_n;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        load;
   logic [1:0]  brightness;
   logic [7:0]  seg;
   logic [3:0]  an;

   int errors = 0;
   int checks = 0;
   int cyc;

   seven_seg_mux #(
      .DIGITS   (4),
      .PRESCALE (4),
      .BRIGHT_W (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .value      (value),
      .dp         (dp),
      .blank      (blank),
      .load       (load),
      .brightness (brightness),
      .seg        (seg),
      .an         (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance to the negedge following posedge n.
   task automatic goto(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) chk("goto", cyc, n);
   endtask

   // Check one full frame of outputs from sample k0 to k0+63; tbl[8d+:8] is the lit seg of digit d.
   task automatic check_frame(input string tag, input int k0, input logic [31:0] tbl,
                              input int bright, input logic [3:0] blk, input int exp_low);
      int mism;
      int low [4];
      int pos, d, p;
      logic lit;
      logic [3:0] ea;
      logic [7:0] es;
      mism = 0;
      for (int i = 0; i < 4; i++) low[i] = 0;
      for (int k = k0; k < k0 + 64; k++) begin
         goto(k);
         pos = (k - 1) % 64;
         d   = pos / 16;
         p   = (pos / 4) % 4;
         lit = (p < bright) && !blk[d];
         ea  = lit ? ~(4'b0001 << d) : 4'hF;
         es  = lit ? tbl[d*8 +: 8] : 8'hFF;
         if (an !== ea || seg !== es) mism++;
         for (int i = 0; i < 4; i++) if (an[i] === 1'b0) low[i]++;
      end
      chk({tag, "_mism"}, mism, 0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_low%0d", tag, i), low[i], blk[i] ? 0 : exp_low);
   endtask

   initial begin
      int dark;
      reset_n = 1'b1; value = '0; dp = '0; blank = '0; load = 1'b0; brightness = 2'd3;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_seg", seg, 8'hFF);
      chk("rst_an", an, 4'hF);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: shadow blanked after reset, nothing lights
      dark = 0;
      for (int k = 1; k <= 200; k++) begin
         goto(k);
         if (an !== 4'hF || seg !== 8'hFF) dark++;
      end
      chk("t1_dark", dark, 0);

      // 2: load 12AF, commit at the next frame boundary (edge 256)
      value = 16'h12AF; dp = 4'b0100; blank = 4'b0000; brightness = 2'd3; load = 1'b1;
      goto(201);
      load = 1'b0;
      goto(256);
      chk("t2_precommit", seg, 8'hFF);
      check_frame("t2", 257, 32'hF924888E, 3, 4'b0000, 12);

      // 3: brightness 1 then 0
      brightness = 2'd1;
      check_frame("t3b1", 321, 32'hF924888E, 1, 4'b0000, 4);
      brightness = 2'd0;
      check_frame("t3b0", 385, 32'hF924888E, 0, 4'b0000, 0);

      // 4: two loads mid-frame; current frame untouched, last one shown next frame
      brightness = 2'd3;
      fork
         check_frame("t4_cur", 449, 32'hF924888E, 3, 4'b0000, 12);
         begin
            goto(466);
            value = 16'h1111; dp = 4'b0000; load = 1'b1;
            goto(467);
            load = 1'b0;
            goto(490);
            value = 16'h2222; load = 1'b1;
            goto(491);
            load = 1'b0;
         end
      join
      check_frame("t4_next", 513, 32'hA4A4A4A4, 3, 4'b0000, 12);

      // 5: load coincident with the frame-boundary tick (edge 640)
      goto(639);
      value = 16'h7E3C; dp = 4'b0001; load = 1'b1;
      goto(640);
      load = 1'b0;
      check_frame("t5", 641, 32'hF886B046, 3, 4'b0000, 12);

      // 6: digit 1 blanked
      goto(710);
      value = 16'h12AF; dp = 4'b0100; blank = 4'b0010; load = 1'b1;
      goto(711);
      load = 1'b0;
      check_frame("t6", 769, 32'hF924888E, 3, 4'b0010, 12);

      // 6b: pending load then async reset mid-slot; pending must be discarded
      goto(860);
      value = 16'h8888; blank = 4'b0000; load = 1'b1;
      goto(861);
      load = 1'b0;
      goto(872);
      chk("t6_prerst_an", an, 4'hB);
      chk("t6_prerst_seg", seg, 8'h24);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_seg", seg, 8'hFF);
      chk("t6_rst_an", an, 4'hF);
      @(negedge clk);
      reset_n = 1'b1;
      dark = 0;
      for (int k = 1; k <= 150; k++) begin
         goto(k);
         if (an !== 4'hF || seg !== 8'hFF) dark++;
      end
      chk("t6_post_dark", dark, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Parametrised multiplexed seven-segment display driver for the board top level. It scans DIGITS common-anode digits, decodes 4-bit hex nibbles, and gates per-digit decimal points and blanking. It adds PWM brightness control and tear-free, frame-synchronised value updates. It replaces the fixed 4-digit, externally clock-enabled driver and carries its own scan prescaler.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8).
PRESCALE, 1024, clk cycles per scan tick (>=1).
BRIGHT_W, 3, width of the brightness input; each digit slot is 2^BRIGHT_W ticks.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
value  in  4*DIGITS  hex nibbles; value[3:0] is digit 0 (rightmost).
dp  in  DIGITS  decimal point enables, 1 = lit.
blank  in  DIGITS  per-digit blank, 1 = dark.
load  in  1  single-cycle strobe; captures value/dp/blank into the pending buffer.
brightness  in  BRIGHT_W  duty level, sampled live; 0 = off.
seg  out  8  active-low cathodes; [0]=a … [6]=g, [7]=dp.
an  out  DIGITS  active-low anodes; an[i] drives digit i.

Behaviour:
- Async reset: seg=8'hFF, an=all 1, all counters 0, pending_valid=0, shadow value=0, shadow dp=0, shadow blank=all 1 (dark until first commit).
- Prescaler pre_cnt counts 0..PRESCALE-1. tick=1 on the cycle pre_cnt==PRESCALE-1, then wraps to 0.
- Slot phase counter, BRIGHT_W bits: increments on tick. On tick with phase==max, phase wraps to 0 and digit advances. digit==DIGITS-1 wraps to 0; this is the frame boundary.
- Lit condition: for current digit d, (phase < brightness) && !shadow_blank[d]. brightness=max gives (2^BRIGHT_W-1)/2^BRIGHT_W duty. Full-on is not provided.
- Output registers update every cycle from the current counter and shadow state (one clk latency):
  - an: only bit d low when lit, else all 1.
  - seg[6:0]: hex decode of shadow nibble d, active low.
    - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
    - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
  - seg[7]: ~shadow_dp[d].
  - seg=8'hFF whenever not lit (no ghost segments).
- Anode changes and segment changes are in the same clock edge.
- Load/commit:
  - load=1 copies value/dp/blank into pending and sets pending_valid.
  - A second load before commit overwrites pending; the last write wins.
  - On the frame-boundary tick with pending_valid=1: shadow<=pending, pending_valid<=0.
  - load coincident with the frame-boundary tick: the new inputs bypass into shadow directly and pending_valid ends 0.
  - No shadow change mid-frame, under any circumstance.
- reset_n asserted mid-frame: immediate return to reset values; the pending update is discarded.
- brightness changes take effect the next cycle; no resync.

Test Plan:
(All cases use DIGITS=4, PRESCALE=4, BRIGHT_W=2: slot=16 clk, frame=64 clk.)
1. Reset, then run 200 clk with no load -> an stays 4'hF and seg stays 8'hFF throughout (shadow blanked).
2. load value=16'h12AF, dp=4'b0100, blank=0, brightness=3; wait for the commit -> per frame:
   - an cycles 1110, 1101, 1011, 0111, each low for 12 of 16 clk;
   - seg = 8'h8E, 8'h88, 8'h24 (dp lit), 8'hF9 in turn;
   - 8'hFF during the dark quarter of each slot.
3. brightness=1 -> each anode is low exactly 4 clk per 16-clk slot. brightness=0 -> an=4'hF continuously.
4. load 16'h1111 at digit 1 mid-frame, then load 16'h2222 before the frame end -> 16'h2222 is shown from the next frame. Digits 2 and 3 of the current frame still show the old value.
5. load asserted exactly on the frame-boundary tick -> new value appears on digit 0 in the immediately following slot.
6. blank=4'b0010 -> digit 1 dark for the entire slot while its anode stays high; other digits unaffected. Assert reset_n low mid-slot -> seg=8'hFF and an=4'hF asynchronously.
